// File: rtl/wb_arbiter.sv
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Write-back port arbiter. Loads take priority, and ALU results
//            that lose arbitration wait in an in-order FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_arbiter #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_LEN   = 4,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic                  alu_wb_en,
    input  logic [ADDR_LEN-1:0]   alu_dest,
    input  logic [WORD_WIDTH-1:0] alu_result,
    input  logic                  ld_valid,
    input  logic [ADDR_LEN-1:0]   ld_dest,
    input  logic [WORD_WIDTH-1:0] ld_data,
    input  logic [ADDR_LEN-1:0]   src1,
    input  logic [ADDR_LEN-1:0]   src2,
    input  logic                  src2_used,
    output logic                  freeze,
    output logic                  hazard,
    output logic [WORD_WIDTH-1:0] result_WB,
    output logic [ADDR_LEN-1:0]   dest_wb,
    output logic                  writeBackEn,
    output logic [15:0]           conflict_cnt
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [ADDR_LEN-1:0]   fifo_dest_q [DEPTH];
    logic [WORD_WIDTH-1:0] fifo_data_q [DEPTH];

    logic [c_PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [c_CNT_W-1:0]    count_q, count_d;
    logic                  wben_q, wben_d;
    logic [ADDR_LEN-1:0]   dest_q, dest_d;
    logic [WORD_WIDTH-1:0] result_q, result_d;
    logic [15:0]           conflict_q, conflict_d;

    logic                  w_accept;
    logic                  w_alu_wr;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_bypass;
    logic                  w_push;
    logic [DEPTH-1:0]      w_match;

    assign freeze   = (count_q == c_FULL);
    assign w_accept = alu_valid && !freeze;
    assign w_alu_wr = w_accept && alu_wb_en;
    assign w_empty  = (count_q == '0);
    assign w_pop    = !ld_valid && !w_empty;
    assign w_bypass = !ld_valid && w_empty && w_alu_wr;
    // Push is gated by freeze through w_accept, so a full FIFO never takes an
    // entry even when the same cycle pops.
    assign w_push   = w_alu_wr && !w_bypass;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        wben_d     = 1'b0;
        dest_d     = dest_q;
        result_d   = result_q;
        conflict_d = conflict_q;

        if (ld_valid) begin
            wben_d   = 1'b1;
            dest_d   = ld_dest;
            result_d = ld_data;
        end else if (w_pop) begin
            wben_d   = 1'b1;
            dest_d   = fifo_dest_q[rd_ptr_q];
            result_d = fifo_data_q[rd_ptr_q];
        end else if (w_bypass) begin
            wben_d   = 1'b1;
            dest_d   = alu_dest;
            result_d = alu_result;
        end

        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (conflict_q != 16'hFFFF) begin
                conflict_d = conflict_q + 16'd1;
            end
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_W'(1);
            2'b01:   count_d = count_q - c_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            wben_q     <= 1'b0;
            dest_q     <= '0;
            result_q   <= '0;
            conflict_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            wben_q     <= wben_d;
            dest_q     <= dest_d;
            result_q   <= result_d;
            conflict_q <= conflict_d;
        end
    end

    // Storage needs no reset: only slots inside the count window are ever read.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            fifo_dest_q[wr_ptr_q] <= alu_dest;
            fifo_data_q[wr_ptr_q] <= alu_result;
        end
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_hazard
            logic [c_PTR_W-1:0] w_offset;
            logic               w_live;
            assign w_offset   = c_PTR_W'(i) - rd_ptr_q;
            assign w_live     = ({1'b0, w_offset} < count_q);
            assign w_match[i] = w_live &&
                                ((fifo_dest_q[i] == src1) ||
                                 (src2_used && (fifo_dest_q[i] == src2)));
        end
    endgenerate

    assign hazard       = |w_match;
    assign writeBackEn  = wben_q;
    assign dest_wb      = dest_q;
    assign result_WB    = result_q;
    assign conflict_cnt = conflict_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Directed self-checking bench for wb_arbiter with a write scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_wb_en;
    logic [3:0]  alu_dest;
    logic [31:0] alu_result;
    logic        ld_valid;
    logic [3:0]  ld_dest;
    logic [31:0] ld_data;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        src2_used;
    logic        freeze;
    logic        hazard;
    logic [31:0] result_WB;
    logic [3:0]  dest_wb;
    logic        writeBackEn;
    logic [15:0] conflict_cnt;

    int total = 0;
    int bad   = 0;
    logic [35:0] sb[$];

    wb_arbiter #(
        .WORD_WIDTH(32),
        .ADDR_LEN  (4),
        .DEPTH     (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_wb_en   (alu_wb_en),
        .alu_dest    (alu_dest),
        .alu_result  (alu_result),
        .ld_valid    (ld_valid),
        .ld_dest     (ld_dest),
        .ld_data     (ld_data),
        .src1        (src1),
        .src2        (src2),
        .src2_used   (src2_used),
        .freeze      (freeze),
        .hazard      (hazard),
        .result_WB   (result_WB),
        .dest_wb     (dest_wb),
        .writeBackEn (writeBackEn),
        .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Register-file side: every write is popped from the scoreboard in order.
    always @(negedge clk) begin
        if (writeBackEn === 1'b1) begin
            check("wb_expected_present", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                logic [35:0] e;
                e = sb.pop_front();
                check("wb_write", 64'({dest_wb, result_WB}), 64'(e));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  k;
        logic acc;

        rst = 1'b1; alu_valid = 0; alu_wb_en = 0; alu_dest = 0; alu_result = 0;
        ld_valid = 0; ld_dest = 0; ld_data = 0; src1 = 0; src2 = 0; src2_used = 0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_wben",     64'(writeBackEn),  64'd0);
        check("rst_dest",     64'(dest_wb),      64'd0);
        check("rst_result",   64'(result_WB),    64'd0);
        check("rst_freeze",   64'(freeze),       64'd0);
        check("rst_hazard",   64'(hazard),       64'd0);
        check("rst_conflict", 64'(conflict_cnt), 64'd0);

        // Bypass with empty FIFO.
        alu_valid = 1; alu_wb_en = 1; alu_dest = 4'd3; alu_result = 32'hAA;
        sb.push_back({4'd3, 32'hAA});
        tick();
        check("byp_wben",     64'(writeBackEn),  64'd1);
        check("byp_dest",     64'(dest_wb),      64'd3);
        check("byp_result",   64'(result_WB),    64'hAA);
        check("byp_conflict", 64'(conflict_cnt), 64'd0);
        alu_valid = 0;
        tick();
        check("idle_wben",    64'(writeBackEn),  64'd0);
        check("idle_hold",    64'(dest_wb),      64'd3);

        // Load and ALU collide: load first, ALU queued.
        ld_valid = 1; ld_dest = 4'd5; ld_data = 32'h55;
        alu_valid = 1; alu_wb_en = 1; alu_dest = 4'd6; alu_result = 32'h66;
        src1 = 4'd6;
        sb.push_back({4'd5, 32'h55});
        sb.push_back({4'd6, 32'h66});
        #1;
        check("cfl_hz_before", 64'(hazard), 64'd0);
        tick();
        check("cfl_c1_dest",   64'(dest_wb),      64'd5);
        check("cfl_c1_hazard", 64'(hazard),       64'd1);
        check("cfl_conflict",  64'(conflict_cnt), 64'd1);
        ld_valid = 0; alu_valid = 0;
        tick();
        check("cfl_c2_dest",   64'(dest_wb),   64'd6);
        check("cfl_c2_result", 64'(result_WB), 64'h66);
        check("cfl_c2_hazard", 64'(hazard),    64'd0);
        src1 = 0;

        // Fill to full under a 6-cycle load burst; upstream holds while frozen.
        k = 1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            ld_valid = (cyc < 6);
            ld_dest  = 4'(8 + cyc);
            ld_data  = 32'h100 + 32'(cyc);
            if (cyc < 6) sb.push_back({4'(8 + cyc), 32'h100 + 32'(cyc)});
            if (cyc == 6) begin
                for (int r = 1; r <= 5; r++) sb.push_back({4'(r), 32'hA0 + 32'(r)});
            end
            alu_valid  = (k <= 5);
            alu_wb_en  = 1;
            alu_dest   = 4'(k);
            alu_result = 32'hA0 + 32'(k);
            #1;
            check($sformatf("fill_freeze_c%0d", cyc), 64'(freeze), 64'(cyc >= 4 && cyc <= 6));
            acc = alu_valid && !freeze;
            tick();
            if (acc) k++;
        end
        check("fill_conflict", 64'(conflict_cnt), 64'd6);
        check("fill_freeze_end", 64'(freeze), 64'd0);

        // hazard through src2 only when src2_used.
        ld_valid = 1; ld_dest = 4'd9; ld_data = 32'h99;
        alu_valid = 1; alu_wb_en = 1; alu_dest = 4'd7; alu_result = 32'h77;
        src1 = 4'd2; src2 = 4'd7; src2_used = 0;
        sb.push_back({4'd9, 32'h99});
        sb.push_back({4'd7, 32'h77});
        tick();
        ld_valid = 0; alu_valid = 0;
        #1;
        check("hz_src2_unused", 64'(hazard), 64'd0);
        src2_used = 1;
        #1;
        check("hz_src2_used", 64'(hazard), 64'd1);
        tick();
        check("hz_after_pop", 64'(hazard), 64'd0);
        src2_used = 0;

        // Reset with three queued ALU entries.
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1; ld_dest = 4'(1 + i); ld_data = 32'h200 + 32'(i);
            alu_valid = 1; alu_wb_en = 1; alu_dest = 4'(10 + i); alu_result = 32'h300 + 32'(i);
            sb.push_back({4'(1 + i), 32'h200 + 32'(i)});
            tick();
        end
        ld_valid = 0; alu_valid = 0; src1 = 4'd11;
        #1;
        check("mid_hazard_q", 64'(hazard), 64'd1);
        rst = 1;
        tick();
        rst = 0;
        #1;
        check("mid_rst_wben",     64'(writeBackEn),  64'd0);
        check("mid_rst_conflict", 64'(conflict_cnt), 64'd0);
        check("mid_rst_freeze",   64'(freeze),       64'd0);
        check("mid_rst_hazard",   64'(hazard),       64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("mid_no_write_%0d", i), 64'(writeBackEn), 64'd0);
        end
        alu_valid = 1; alu_wb_en = 1; alu_dest = 4'd4; alu_result = 32'h44;
        sb.push_back({4'd4, 32'h44});
        tick();
        alu_valid = 0;
        check("post_byp_wben", 64'(writeBackEn), 64'd1);
        check("post_byp_dest", 64'(dest_wb),     64'd4);
        tick();
        tick();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
